// File: rtl/round_sat_pipe_if.sv
// round_sat_pipe_if: input beat stream, output beat stream and saturation counter access for round_sat_pipe
//   i_data/i_mode/i_vld -> i_rdy : upstream beats (ch0 in LSBs) with per-beat rounding mode
//   o_data/o_sat/o_vld <- o_rdy  : downstream rounded, saturated beats with per-channel saturation flags
//   i_sat_clr -> o_sat_cnt       : clear and read the saturated-beat counter
interface round_sat_pipe_if #(
    parameter int N_CH  = 4,
    parameter int W_IN  = 32,
    parameter int W_OUT = 16,
    parameter int W_CNT = 16
);
    logic [N_CH*W_IN-1:0]  i_data;
    logic [1:0]            i_mode;
    logic                  i_vld;
    logic                  i_rdy;
    logic [N_CH*W_OUT-1:0] o_data;
    logic [N_CH-1:0]       o_sat;
    logic                  o_vld;
    logic                  o_rdy;
    logic                  i_sat_clr;
    logic [W_CNT-1:0]      o_sat_cnt;
    modport slave (
        input  i_data, i_mode, i_vld, o_rdy, i_sat_clr,
        output i_rdy, o_data, o_sat, o_vld, o_sat_cnt
    );
    modport master (
        output i_data, i_mode, i_vld, o_rdy, i_sat_clr,
        input  i_rdy, o_data, o_sat, o_vld, o_sat_cnt
    );
endinterface

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: 2-stage multi-channel signed rounding (4 modes) and saturation with valid/ready flow and a saturation counter
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : round_sat_pipe_if slave (input beats, output beats, i_sat_clr, o_sat_cnt)
module round_sat_pipe #(
    parameter int N_CH  = 4,
    parameter int W_IN  = 32,
    parameter int FRAC  = 16,
    parameter int W_OUT = 16,
    parameter int W_CNT = 16
) (
    input logic              clk,
    input logic              rst,
    round_sat_pipe_if.slave  bus
);
    localparam int W_R = W_IN + 1 - FRAC;
    localparam logic [W_IN:0] ONE = {{W_IN{1'b0}}, 1'b1};
    localparam logic [W_IN:0] H   = ONE << (FRAC - 1);
    localparam logic [W_IN:0] HM1 = H - ONE;
    logic                  s1_vld;
    logic [N_CH*W_R-1:0]   s1_r;
    logic [N_CH*W_R-1:0]   s1_d;
    logic                  o_vld;
    logic [N_CH*W_OUT-1:0] o_data;
    logic [N_CH-1:0]       o_sat;
    logic [N_CH*W_OUT-1:0] s2_d;
    logic [N_CH-1:0]       s2_s;
    logic [W_CNT-1:0]      cnt;
    logic                  adv2;
    logic                  i_rdy;
    assign adv2  = !o_vld || bus.o_rdy;
    assign i_rdy = !s1_vld || adv2;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [W_IN-1:0]    x;
        logic [W_IN:0]      add;
        logic [W_R-1:0]     r;
        logic [W_R-W_OUT:0] top;
        logic               sat;
        assign x = bus.i_data[c*W_IN +: W_IN];
        // convergent adds h or h-1 depending on the kept LSB; half-away subtracts one for negatives
        always_comb add = bus.i_mode == 2'd0 ? '0 :
                          bus.i_mode == 2'd1 ? H :
                          bus.i_mode == 2'd2 ? (x[FRAC] ? H : HM1) :
                                               (x[W_IN-1] ? HM1 : H);
        // one guard bit keeps the sum exact; the logical shift leaves the sign-correct upper bits in range
        assign s1_d[c*W_R +: W_R] = W_R'(({x[W_IN-1], x} + add) >> FRAC);
        assign r   = s1_r[c*W_R +: W_R];
        // value fits W_OUT bits only when the sign bit and all dropped upper bits agree
        assign top = r[W_R-1:W_OUT-1];
        assign sat = !(&top || !(|top));
        assign s2_s[c] = sat;
        assign s2_d[c*W_OUT +: W_OUT] = !sat ? r[W_OUT-1:0] :
                                        r[W_R-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
        end else if (i_rdy) begin
            s1_vld <= bus.i_vld;
            if (bus.i_vld) s1_r <= s1_d;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_sat  <= '0;
        end else if (adv2) begin
            o_vld <= s1_vld;
            if (s1_vld) begin
                o_data <= s2_d;
                o_sat  <= s2_s;
            end
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (bus.i_sat_clr) cnt <= '0;
        else if (o_vld && bus.o_rdy && |o_sat && !(&cnt)) cnt <= cnt + W_CNT'(1);
    assign bus.i_rdy     = i_rdy;
    assign bus.o_vld     = o_vld;
    assign bus.o_data    = o_data;
    assign bus.o_sat     = o_sat;
    assign bus.o_sat_cnt = cnt;
endmodule
